mul_arbiter: RTL and testbench
==============================

MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter N SHALL be declared: default 8, operand width in bits.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 Port req SHALL be: input, 4 bits, one request line per requester i (bit i).
REQ-005 Port x_in SHALL be: input, 4*N bits, operand x of requester i at bits [i*N +: N].
REQ-006 Port y_in SHALL be: input, 4*N bits, operand y of requester i at bits [i*N +: N].
REQ-007 Port gnt SHALL be: output, 4 bits, registered one-hot acceptance pulse.
REQ-008 Port done SHALL be: output, 4 bits, registered one-hot result-valid pulse.
REQ-009 Port p SHALL be: output, 2*N bits, registered unsigned product of the last completed operation.
REQ-010 Port busy SHALL be: output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-011 The block SHALL share exactly one N x N unsigned multiplier (the existing mymul block) among 4 requesters.
REQ-012 FSM states SHALL be IDLE and MUL, plus MUL2 only when MUL_ARB_PIPE_EN is defined.
REQ-013 In IDLE with req != 0, the next edge SHALL select a winner, latch its x/y into x_r/y_r, set owner, pulse gnt[winner] for 1 cycle, and enter MUL.
REQ-014 In IDLE with req == 0, the FSM SHALL stay in IDLE with gnt = 0.
REQ-015 Arbitration SHALL be round-robin: search starts at (ptr+1) mod 4, and ptr updates to the winner on each grant.
REQ-016 In MUL without the macro, the next edge SHALL load p <= x_r*y_r (full 2N bits, no truncation), pulse done[owner] for 1 cycle, and return to IDLE.
REQ-017 Latency SHALL be gnt to done = 1 cycle; throughput SHALL be one operation per 2 cycles.
REQ-018 req SHALL NOT be sampled outside IDLE; requests arriving during MUL/MUL2 wait without loss.
REQ-019 A requester SHALL hold req, x_in and y_in stable until it sees gnt; req still high in the cycle after gnt SHALL count as a new request.
REQ-020 p SHALL hold its value between done pulses.
REQ-021 gnt and done SHALL never have more than one bit set and SHALL never be high in the same cycle.

Reset
REQ-022 With rst high at an edge, the block SHALL force state=IDLE, gnt=0, done=0, p=0, x_r=y_r=0, owner=0, ptr=3 (requester 0 wins first).
REQ-023 A reset during MUL/MUL2 SHALL abort the operation with no done pulse; rst SHALL take priority over all other events.

Configuration
REQ-024 Macro MUL_ARB_PIPE_EN, when defined, SHALL insert state MUL2 and a product register prod_r.
  - MUL loads prod_r <= x_r*y_r.
  - MUL2 loads p <= prod_r, pulses done, returns to IDLE.
  - Latency gnt to done becomes 2 cycles; one operation per 3 cycles.
REQ-025 When MUL_ARB_PIPE_EN is undefined, the block SHALL implement REQ-016/017 exactly with no prod_r.

Verification (N=8, macro undefined unless stated)
REQ-026 req=0010, x1=0x0F, y1=0x11 after reset -> gnt=0010 at T+1, done=0010 and p=0x00FF at T+2, busy high for 1 cycle.
REQ-027 req=1111 held, each requester dropping its bit after its gnt -> grants 0,1,2,3 at 2-cycle spacing; products correct per requester.
REQ-028 x0=0xFF, y0=0xFF -> p=0xFE01; x0=0x00, y0=0xAB -> p=0x0000.
REQ-029 req0 and req2 both held high continuously -> grant sequence 0,2,0,2; no starvation.
REQ-030 rst asserted in MUL -> next cycle: done=0, p=0, busy=0; a following req=1000 is granted to requester 3 with correct result.
REQ-031 MUL_ARB_PIPE_EN defined, req=0100, x2=0x12, y2=0x34 -> gnt=0100 at T+1, done=0100 with p=0x03A8 at T+3.

Source files
------------

// File: rtl/mul_arbiter.sv
// Purpose: shares one N x N unsigned multiplier among 4 round-robin requesters (MUL_ARB_PIPE_EN adds a product pipeline stage).
// Latency: gnt to done 1 cycle (2 with MUL_ARB_PIPE_EN); one operation per 2 cycles (3 with the macro).
// Backpressure: req is sampled only in IDLE; a requester holds req/x_in/y_in until it sees its gnt pulse.

module mymul #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] prod
);
    assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
endmodule

module mul_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] x_in,
    input  logic [4*N-1:0] y_in,
    output logic [3:0]     gnt,
    output logic [3:0]     done,
    output logic [2*N-1:0] p,
    output logic           busy
);
`ifdef MUL_ARB_PIPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, MUL2 = 2'd2} state_t;
    logic [2*N-1:0] prod_q, prod_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

    state_t         state_q, state_d;
    logic [3:0]     gnt_q, gnt_d;
    logic [3:0]     done_q, done_d;
    logic [2*N-1:0] p_q, p_d;
    logic [N-1:0]   x_q, x_d;
    logic [N-1:0]   y_q, y_d;
    logic [1:0]     owner_q, owner_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [2*N-1:0] mul_out;

    logic [1:0]     win;
    logic [1:0]     idx;
    logic           found;

    mymul #(.N(N)) u_mymul (
        .a    (x_q),
        .b    (y_q),
        .prod (mul_out)
    );

    // Round-robin: the requester just after the last winner has highest priority.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = 4'b0000;
        done_d  = 4'b0000;
        p_d     = p_q;
        x_d     = x_q;
        y_d     = y_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef MUL_ARB_PIPE_EN
        prod_d  = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    x_d     = x_in[int'(win)*N +: N];
                    y_d     = y_in[int'(win)*N +: N];
                    owner_d = win;
                    ptr_d   = win;
                    gnt_d   = 4'b0001 << win;
                    state_d = MUL;
                end
            end
            MUL: begin
`ifdef MUL_ARB_PIPE_EN
                prod_d  = mul_out;
                state_d = MUL2;
`else
                p_d     = mul_out;
                done_d  = 4'b0001 << owner_q;
                state_d = IDLE;
`endif
            end
`ifdef MUL_ARB_PIPE_EN
            MUL2: begin
                p_d     = prod_q;
                done_d  = 4'b0001 << owner_q;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            done_q  <= 4'b0000;
            p_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            owner_q <= 2'd0;
            ptr_q   <= 2'd3;
`ifdef MUL_ARB_PIPE_EN
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            p_q     <= p_d;
            x_q     <= x_d;
            y_q     <= y_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef MUL_ARB_PIPE_EN
            prod_q  <= prod_d;
`endif
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign p    = p_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized bench for mul_arbiter with a transaction-level reference model and directed literal checks.
module tb_mul_arbiter;
    localparam int N = 8;
`ifdef MUL_ARB_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*N-1:0] x_in;
    logic [4*N-1:0] y_in;
    logic [3:0]     gnt;
    logic [3:0]     done;
    logic [2*N-1:0] p;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    mul_arbiter #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .x_in (x_in),
        .y_in (y_in),
        .gnt  (gnt),
        .done (done),
        .p    (p),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: an operation is a countdown of LAT cycles after its grant.
    int          m_ptr = 3;
    int          m_rem = 0;
    int          m_owner = 0;
    logic [15:0] m_prod = '0;
    logic [3:0]  exp_gnt = '0;
    logic [3:0]  exp_done = '0;
    logic [15:0] exp_p = '0;
    logic        exp_busy = 1'b0;

    always @(posedge clk) begin
        exp_gnt  = '0;
        exp_done = '0;
        if (rst) begin
            exp_p = '0;
            m_ptr = 3;
            m_rem = 0;
        end else if (m_rem == 0) begin
            if (req != 0) begin
                int w;
                w = -1;
                for (int k = 1; k <= 4; k++)
                    if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                m_owner = w;
                m_ptr   = w;
                m_prod  = 16'(x_in[w*N +: N]) * 16'(y_in[w*N +: N]);
                exp_gnt = 4'b0001 << w;
                m_rem   = LAT;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                exp_done = 4'b0001 << m_owner;
                exp_p    = m_prod;
            end
        end
        exp_busy = (m_rem != 0);
        #1;
        check("cmp_gnt",  gnt,  exp_gnt);
        check("cmp_done", done, exp_done);
        check("cmp_p",    p,    exp_p);
        check("cmp_busy", busy, exp_busy);
    end

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_op(input int i, input logic [7:0] xv, input logic [7:0] yv, input logic [15:0] pe);
        @(negedge clk);
        req = 4'b0001 << i;
        x_in[i*N +: N] = xv;
        y_in[i*N +: N] = yv;
        @(posedge clk); #2;
        check("op_gnt",  gnt,  4'b0001 << i);
        check("op_busy", busy, 1);
        @(negedge clk);
        req = '0;
        repeat (LAT) @(posedge clk);
        #2;
        check("op_done",      done, 4'b0001 << i);
        check("op_p",         p,    pe);
        check("op_busy_fall", busy, 0);
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r;
        r = -1;
        for (int j = 0; j < 4; j++) if (v[j]) r = j;
        return r;
    endfunction

    // Collects up to four grant indices and cycle stamps; drop_on_gnt releases a requester once served.
    task automatic collect_grants(input bit drop_on_gnt, output int seq[4], output int cyc[4], output int n);
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(posedge clk); #2;
            if (gnt != 0) begin
                seq[n] = onehot_idx(gnt);
                cyc[n] = c;
                n++;
            end
            @(negedge clk);
            if (drop_on_gnt) req = req & ~gnt;
        end
    endtask

    initial begin
        int seq[4];
        int cyc[4];
        int n;

        rst  = 1'b1;
        req  = '0;
        x_in = '0;
        y_in = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt",  gnt,  0);
        check("rst_done", done, 0);
        check("rst_p",    p,    0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        do_op(1, 8'h0F, 8'h11, 16'h00FF);
        do_op(0, 8'hFF, 8'hFF, 16'hFE01);
        do_op(0, 8'h00, 8'hAB, 16'h0000);

        // All four requesting: served 0,1,2,3 back to back.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            x_in[i*N +: N] = 8'($urandom);
            y_in[i*N +: N] = 8'($urandom);
        end
        req = 4'b1111;
        collect_grants(1'b1, seq, cyc, n);
        check("rr4_count", n, 4);
        for (int k = 0; k < n; k++) check("rr4_order", seq[k], k);
        for (int k = 1; k < n; k++) check("rr4_spacing", cyc[k] - cyc[k-1], LAT + 1);

        // Two requesters held high continuously alternate.
        do_reset();
        x_in[0 +: N] = 8'h03; y_in[0 +: N] = 8'h05;
        x_in[2*N +: N] = 8'h07; y_in[2*N +: N] = 8'h09;
        req = 4'b0101;
        collect_grants(1'b0, seq, cyc, n);
        check("rr2_count", n, 4);
        if (n == 4) begin
            check("rr2_g0", seq[0], 0);
            check("rr2_g1", seq[1], 2);
            check("rr2_g2", seq[2], 0);
            check("rr2_g3", seq[3], 2);
        end
        req = '0;
        repeat (4) @(negedge clk);

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        req = 4'b0001;
        x_in[0 +: N] = 8'h21; y_in[0 +: N] = 8'h33;
        @(posedge clk); #2;
        check("abort_gnt", gnt, 4'b0001);
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        @(posedge clk); #2;
        check("abort_done", done, 0);
        check("abort_p",    p,    0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(3, 8'h0C, 8'h0D, 16'h009C);
        do_op(2, 8'h12, 8'h34, 16'h03A8);

        // Random traffic, with occasional resets, against the model.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 4; i++) begin
                if (exp_gnt[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        x_in[i*N +: N] = 8'($urandom);
                        y_in[i*N +: N] = 8'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    x_in[i*N +: N] = 8'($urandom);
                    y_in[i*N +: N] = 8'($urandom);
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
